mdio_sched: RTL and testbench

MDIO_SCHED -- requirements
Module: mdio_sched

---
 rtl/mdio_pkg.sv | 31 +++
 rtl/mdio_sched_if.sv | 36 +++
 rtl/mdio_rr_arb.sv | 29 ++
 rtl/mdio_sched.sv | 154 +++++++++++++++
 tb/tb_mdio_sched.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO transaction scheduler.
// Used by mdio_sched (and its MDIO_SCHED_POLL_EN link poller) and by mdio_rr_arb.
package mdio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [4:0]  reg_adr;
    logic [15:0] wdata;
  } mdio_cmd_t;

  localparam logic        MDIO_RD       = 1'b1;
  localparam logic        MDIO_WR       = 1'b0;
  localparam logic [4:0]  BMSR_ADR      = 5'd1;
  localparam int          BMSR_LINK_BIT = 2;
  localparam logic [15:0] RDATA_TMO     = 16'hFFFF;

  localparam mdio_cmd_t CMD_RST = '{rw: MDIO_RD, reg_adr: 5'd0, wdata: 16'h0000};

  // Command issued by the internal link poller: read of the basic status register.
  function automatic mdio_cmd_t poll_cmd();
    return '{rw: MDIO_RD, reg_adr: BMSR_ADR, wdata: 16'h0000};
  endfunction

endpackage

// File: rtl/mdio_sched_if.sv
// Requester and frame-engine bundle of the MDIO scheduler.
// slave = scheduler side, master = requesters plus frame engine.
interface mdio_sched_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_rw;
  logic [5*NREQ-1:0]    req_reg_adr;
  logic [16*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]      done;
  logic [15:0]          rsp_rdata;
  logic                 rsp_err;
  logic                 busy;

  logic                 eng_start;
  logic                 eng_rw;
  logic [4:0]           eng_phy_adr;
  logic [4:0]           eng_reg_adr;
  logic [15:0]          eng_wdata;
  logic                 eng_done;
  logic                 eng_ack;
  logic [15:0]          eng_rdata;

  modport slave (
    input  req, req_rw, req_reg_adr, req_wdata, eng_done, eng_ack, eng_rdata,
    output done, rsp_rdata, rsp_err, busy,
    output eng_start, eng_rw, eng_phy_adr, eng_reg_adr, eng_wdata
  );

  modport master (
    output req, req_rw, req_reg_adr, req_wdata, eng_done, eng_ack, eng_rdata,
    input  done, rsp_rdata, rsp_err, busy,
    input  eng_start, eng_rw, eng_phy_adr, eng_reg_adr, eng_wdata
  );

endinterface

// File: rtl/mdio_rr_arb.sv
// Combinational round-robin pick: search starts one past the last granted index.
module mdio_rr_arb
  import mdio_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  int pos;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    pos   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      pos = (int'(last) + i) % NREQ;
      if (!any && req[pos]) begin
        any   = 1'b1;
        grant = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/mdio_sched.sv
// MDIO transaction scheduler: arbitrates requesters onto a single frame engine.
// Define MDIO_SCHED_POLL_EN to add the internal BMSR link poller and link_up port.
module mdio_sched
  import mdio_pkg::*;
#(
  parameter int         NREQ     = 3,
  parameter logic [4:0] PHY_ADR  = 5'd1,
  parameter int         TIMEOUT  = 200,
  parameter int         POLL_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MDIO_SCHED_POLL_EN
  output logic        link_up,
`endif
  mdio_sched_if.slave bus
);

  localparam int               IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  state_t           state_q, state_d;
  mdio_cmd_t        cmd_q, cmd_sel;
  logic [IDX_W-1:0] win_q, last_q, arb_idx;
  logic             arb_any, take, poll_due, is_poll_q;
  logic [TMO_W-1:0] tmo_q;
  logic [15:0]      rdata_q;
  logic             err_q;

  mdio_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (bus.req),
    .last  (last_q),
    .grant (arb_idx),
    .any   (arb_any)
  );

  // A due poll pre-empts the external winner.
  always_comb begin
    cmd_sel.rw      = bus.req_rw[arb_idx];
    cmd_sel.reg_adr = bus.req_reg_adr[5*int'(arb_idx) +: 5];
    cmd_sel.wdata   = bus.req_wdata[16*int'(arb_idx) +: 16];
    if (poll_due) cmd_sel = poll_cmd();
    take = poll_due | arb_any;
  end

  always_comb begin
    state_d       = state_q;
    bus.eng_start = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = '0;
    unique case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (take) state_d = ISSUE;
      end
      ISSUE: begin
        bus.eng_start = 1'b1;
        state_d       = WAIT;
      end
      WAIT: begin
        if (bus.eng_done || tmo_q == TMO_LAST) state_d = RESP;
      end
      RESP: begin
        if (!is_poll_q) bus.done[win_q] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.eng_rw      = cmd_q.rw;
  assign bus.eng_phy_adr = PHY_ADR;
  assign bus.eng_reg_adr = cmd_q.reg_adr;
  assign bus.eng_wdata   = cmd_q.wdata;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= CMD_RST;
      win_q     <= '0;
      last_q    <= LAST_RST;
      is_poll_q <= 1'b0;
      tmo_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            cmd_q     <= cmd_sel;
            is_poll_q <= poll_due;
            if (!poll_due) begin
              win_q  <= arb_idx;
              last_q <= arb_idx;
            end
          end
        end
        ISSUE: tmo_q <= '0;
        WAIT: begin
          tmo_q <= tmo_q + TMO_W'(1);
          // A completing engine wins over a timeout landing on the same cycle.
          if (bus.eng_done) begin
            rdata_q <= (cmd_q.rw == MDIO_RD) ? bus.eng_rdata : 16'h0000;
            err_q   <= ~bus.eng_ack;
          end else if (tmo_q == TMO_LAST) begin
            rdata_q <= RDATA_TMO;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MDIO_SCHED_POLL_EN
  localparam int              PC_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(POLL_DIV - 1);

  logic [PC_W-1:0] poll_cnt_q;
  logic            poll_due_q;

  assign poll_due = poll_due_q;

  // The due flag is set after the grant-clear so a wrap on the grant cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_q <= '0;
      poll_due_q <= 1'b0;
      link_up    <= 1'b0;
    end else begin
      if (state_q == IDLE && poll_due_q) poll_due_q <= 1'b0;
      if (poll_cnt_q == PC_LAST) begin
        poll_cnt_q <= '0;
        poll_due_q <= 1'b1;
      end else begin
        poll_cnt_q <= poll_cnt_q + PC_W'(1);
      end
      if (state_q == WAIT && bus.eng_done && is_poll_q && bus.eng_ack)
        link_up <= bus.eng_rdata[BMSR_LINK_BIT];
    end
  end
`else
  assign poll_due = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_sched.sv
// Scoreboard bench for mdio_sched with a behavioural frame engine.
// Poller checks are included when MDIO_SCHED_POLL_EN is defined.
module tb_mdio_sched;
  import mdio_pkg::*;

  localparam int         NREQ = 3;
  localparam int         TMO  = 20;
  localparam int         PDIV = 400;
  localparam logic [4:0] PHY  = 5'd7;

  typedef struct {
    logic [NREQ-1:0] done;
    logic [15:0]     rdata;
    logic            err;
    logic            rw;
    logic [4:0]      reg_adr;
    logic [15:0]     wdata;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mdio_sched_if #(.NREQ(NREQ)) bus ();
`ifdef MDIO_SCHED_POLL_EN
  logic link_up;
`endif

  mdio_sched #(.NREQ(NREQ), .PHY_ADR(PHY), .TIMEOUT(TMO), .POLL_DIV(PDIV)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef MDIO_SCHED_POLL_EN
    .link_up (link_up),
`endif
    .bus     (bus)
  );

  int         n_vec = 0, n_err = 0;
  int         n_start = 0, start_cyc = 0;
  exp_t       sb[$];
  logic [4:0] start_log[$];

  int          eng_lat   = 2;
  logic        eng_ack_v = 1'b1;
  logic [15:0] eng_rd_v  = 16'h0000;
  logic        hang      = 1'b0;
  logic        spur_tgl  = 1'b0;
  logic        spur_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame engine: answers eng_start after eng_lat cycles unless hung.
  initial begin
    bus.eng_done  = 1'b0;
    bus.eng_ack   = 1'b0;
    bus.eng_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.eng_start) begin
        n_start++;
        start_cyc = cyc;
        start_log.push_back(bus.eng_reg_adr);
        if (!hang) begin
          repeat (eng_lat - 1) @(negedge clk);
          bus.eng_ack   = eng_ack_v;
          bus.eng_rdata = eng_rd_v;
          bus.eng_done  = 1'b1;
          @(negedge clk);
          bus.eng_done  = 1'b0;
          bus.eng_rdata = 16'hDEAD;
        end
      end else if (spur_tgl != spur_seen) begin
        spur_seen     = spur_tgl;
        bus.eng_ack   = 1'b1;
        bus.eng_rdata = 16'h5555;
        bus.eng_done  = 1'b1;
        @(negedge clk);
        bus.eng_done  = 1'b0;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (bus.done != '0) begin
        if (sb.size() == 0) begin
          check_eq("unexp_done", 32'(bus.done), 32'd0);
        end else begin
          m = sb.pop_front();
          check_eq("done", 32'(bus.done), 32'(m.done));
          check_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(m.rdata));
          check_eq("rsp_err", 32'(bus.rsp_err), 32'(m.err));
          check_eq("eng_rw_hold", 32'(bus.eng_rw), 32'(m.rw));
          check_eq("eng_reg_hold", 32'(bus.eng_reg_adr), 32'(m.reg_adr));
          check_eq("eng_wdata_hold", 32'(bus.eng_wdata), 32'(m.wdata));
          check_eq("eng_phy", 32'(bus.eng_phy_adr), 32'(PHY));
          if (m.lat >= 0) check_eq("done_latency", 32'(cyc - start_cyc), 32'(m.lat));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic rw, input logic [4:0] ra, input logic [15:0] wd);
    bus.req_rw[i]            = rw;
    bus.req_reg_adr[i*5 +: 5]  = ra;
    bus.req_wdata[i*16 +: 16] = wd;
  endtask

  task automatic push(input logic [NREQ-1:0] d, input logic [15:0] rd, input logic er,
                      input logic rw, input logic [4:0] ra, input logic [15:0] wd, input int lat);
    exp_t e;
    e.done = d; e.rdata = rd; e.err = er; e.rw = rw; e.reg_adr = ra; e.wdata = wd; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic txn(input int i, input logic rw, input logic [4:0] ra, input logic [15:0] wd,
                     input logic [15:0] rd, input logic ack, input int lat,
                     input logic [15:0] x_rd, input logic x_err, input int x_lat);
    int c = 0;
    eng_rd_v = rd; eng_ack_v = ack; eng_lat = lat;
    set_req(i, rw, ra, wd);
    push(NREQ'(1 << i), x_rd, x_err, rw, ra, wd, x_lat);
    bus.req[i] = 1'b1;
    do begin @(negedge clk); c++; end while (!bus.done[i] && c < 300);
    bus.req[i] = 1'b0;
    check_eq("txn_done", 32'(bus.done[i]), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int c = 0;
    while (!bus.eng_start && c < 50) begin @(negedge clk); c++; end
    check_eq(tag, 32'(bus.eng_start), 32'd1);
  endtask

  task automatic chk_reset(input string p);
    check_eq({p, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({p, "_done"}, 32'(bus.done), 32'd0);
    check_eq({p, "_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    check_eq({p, "_err"}, 32'(bus.rsp_err), 32'd0);
    check_eq({p, "_start"}, 32'(bus.eng_start), 32'd0);
    check_eq({p, "_eng_rw"}, 32'(bus.eng_rw), 32'd1);
    check_eq({p, "_eng_reg"}, 32'(bus.eng_reg_adr), 32'd0);
    check_eq({p, "_eng_wdata"}, 32'(bus.eng_wdata), 32'd0);
`ifdef MDIO_SCHED_POLL_EN
    check_eq({p, "_link_up"}, 32'(link_up), 32'd0);
`endif
  endtask

  initial begin
    int s, k, c, last, rst_cyc, n;
    bus.req = '0; bus.req_rw = '0; bus.req_reg_adr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;

    s = n_start;
    txn(0, MDIO_RD, 5'd2, 16'h0000, 16'h001C, 1'b1, 2, 16'h001C, 1'b0, -1);
    check_eq("single_starts", 32'(n_start - s), 32'd1);
    txn(1, MDIO_WR, 5'd4, 16'hBEEF, 16'h1234, 1'b1, 3, 16'h0000, 1'b0, -1);
    txn(2, MDIO_RD, 5'd3, 16'h0000, 16'hABCD, 1'b0, 2, 16'hABCD, 1'b1, -1);
    hang = 1'b1;
    txn(0, MDIO_RD, 5'd6, 16'h0000, 16'h0000, 1'b1, 2, 16'hFFFF, 1'b1, TMO + 2);
    hang = 1'b0;

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    eng_rd_v = 16'h0F0F; eng_ack_v = 1'b1; eng_lat = 2;
    set_req(0, MDIO_RD, 5'd8, 16'h0000);
    set_req(1, MDIO_WR, 5'd9, 16'h1111);
    set_req(2, MDIO_RD, 5'd10, 16'h0000);
    push(3'b001, 16'h0F0F, 1'b0, MDIO_RD, 5'd8, 16'h0000, -1);
    push(3'b010, 16'h0000, 1'b0, MDIO_WR, 5'd9, 16'h1111, -1);
    push(3'b100, 16'h0F0F, 1'b0, MDIO_RD, 5'd10, 16'h0000, -1);
    push(3'b001, 16'h0F0F, 1'b0, MDIO_RD, 5'd8, 16'h0000, -1);
    bus.req = '1;
    k = 0; c = 0; last = 0;
    while (k < 4 && c < 200) begin
      @(negedge clk); c++;
      if (bus.done != '0) begin
        k++;
        if (k > 1) check_eq("b2b_gap", 32'(cyc - last), 32'd4);
        last = cyc;
      end
    end
    bus.req = '0;
    check_eq("rr_grants", 32'(k), 32'd4);
    repeat (3) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    spur_tgl = ~spur_tgl;
    repeat (6) @(negedge clk);
    check_eq("spur_busy", 32'(bus.busy), 32'd0);
    check_eq("spur_rdata", 32'(bus.rsp_rdata), 32'h0F0F);

    eng_rd_v = 16'h4242;
    set_req(1, MDIO_RD, 5'd14, 16'h0000);
    push(3'b010, 16'h4242, 1'b0, MDIO_RD, 5'd14, 16'h0000, -1);
    bus.req[1] = 1'b1;
    @(negedge clk);
    bus.req[1] = 1'b0;
    check_eq("grant_busy", 32'(bus.busy), 32'd1);
    c = 0;
    while (!bus.done[1] && c < 100) begin @(negedge clk); c++; end
    check_eq("drop_done", 32'(bus.done[1]), 32'd1);

    hang = 1'b1;
    set_req(2, MDIO_RD, 5'd11, 16'h0000);
    bus.req[2] = 1'b1;
    wait_start("abort_start");
    bus.req[2] = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("abort");
    rst = 1'b0;
    hang = 1'b0;
    rst_cyc = cyc;
    repeat (TMO + 5) @(negedge clk);
    check_eq("abort_idle", 32'(bus.busy), 32'd0);
    check_eq("abort_sb", 32'(sb.size()), 32'd0);

`ifdef MDIO_SCHED_POLL_EN
    while (cyc - rst_cyc < PDIV - 10) @(negedge clk);
    check_eq("link_init", 32'(link_up), 32'd0);
    hang = 1'b1;
    set_req(1, MDIO_RD, 5'd12, 16'h0000);
    push(3'b010, 16'hFFFF, 1'b1, MDIO_RD, 5'd12, 16'h0000, TMO + 2);
    bus.req[1] = 1'b1;
    wait_start("poll_blk_start");
    bus.req[1] = 1'b0;
    @(negedge clk);
    hang = 1'b0;
    eng_rd_v = 16'h7849; eng_ack_v = 1'b1; eng_lat = 2;
    set_req(0, MDIO_RD, 5'd13, 16'h0000);
    push(3'b001, 16'h7849, 1'b0, MDIO_RD, 5'd13, 16'h0000, -1);
    bus.req[0] = 1'b1;
    c = 0;
    while (!bus.done[0] && c < 200) begin @(negedge clk); c++; end
    bus.req[0] = 1'b0;
    check_eq("poll_req0_done", 32'(bus.done[0]), 32'd1);
    check_eq("poll_wins", 32'(start_log[start_log.size() - 2]), 32'(BMSR_ADR));
    check_eq("req0_after_poll", 32'(start_log[start_log.size() - 1]), 32'd13);
    check_eq("link_7849", 32'(link_up), 32'd0);

    eng_rd_v = 16'h786D;
    n = start_log.size(); c = 0;
    while (start_log.size() == n && c < PDIV + 50) begin @(negedge clk); c++; end
    repeat (6) @(negedge clk);
    check_eq("poll2_reg", 32'(start_log[start_log.size() - 1]), 32'(BMSR_ADR));
    check_eq("link_786d", 32'(link_up), 32'd1);

    eng_rd_v = 16'h7849; eng_ack_v = 1'b0;
    n = start_log.size(); c = 0;
    while (start_log.size() == n && c < PDIV + 50) begin @(negedge clk); c++; end
    repeat (6) @(negedge clk);
    check_eq("poll3_seen", 32'(start_log.size()), 32'(n + 1));
    check_eq("link_hold_noack", 32'(link_up), 32'd1);
`else
    n = rst_cyc;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
